// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned approximate multiplier: each multiplier bit-pair becomes one
// half-adder row (low K columns optionally OR-sum/no-carry), rows summed into 2N bits.

module approx_mul_ha_row #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic [N-1:0] i_y,
  input  logic         i_x0,
  input  logic         i_x1,
  input  logic         i_approx,
  output logic [N+1:0] o_row
);
  logic [N-1:0] w_a;
  logic [N:1]   w_b;
  logic [N-1:0] w_s;
  logic [N:2]   w_c;

  assign w_a    = i_y & {N{i_x0}};
  assign w_b    = i_y & {N{i_x1}};
  assign w_s[0] = w_a[0];

  for (genvar j = 1; j < N; j++) begin : g_col
    if (j < K) begin : g_apx
      assign w_s[j]   = i_approx ? (w_a[j] | w_b[j]) : (w_a[j] ^ w_b[j]);
      assign w_c[j+1] = ~i_approx & w_a[j] & w_b[j];
    end else begin : g_ex
      assign w_s[j]   = w_a[j] ^ w_b[j];
      assign w_c[j+1] = w_a[j] & w_b[j];
    end
  end

  // b_N sits just above the sum bits; carries land one column up
  assign o_row = {1'b0, w_b[N], w_s} + {1'b0, w_c, 2'b00};
endmodule

module approx_mul_ha_pipe #(
  parameter int N = 8,
  parameter int K = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_x,
  input  logic [N-1:0]   in_y,
  input  logic           in_approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p
);
  localparam int ROWS = N / 2;
  localparam int PW   = 2 * N;

  if ((N % 2) != 0 || N < 4 || K > N) begin : g_bad_param
    $fatal(1, "approx_mul_ha_pipe: illegal N/K");
  end

  logic [3:1]                r_vld_pipe;
  logic                      w_ld1, w_ld2, w_ld3;
  logic [N-1:0]              r_x, r_y;
  logic                      r_ap;
  logic [ROWS-1:0][N+1:0]    w_rows, r_rows;
  logic [PW-1:0]             w_sum, r_p;

  // each stage advances if empty or if the stage downstream advances
  assign w_ld3     = ~r_vld_pipe[3] | out_ready;
  assign w_ld2     = ~r_vld_pipe[2] | w_ld3;
  assign w_ld1     = ~r_vld_pipe[1] | w_ld2;
  assign in_ready  = w_ld1;
  assign out_valid = r_vld_pipe[3];
  assign out_p     = r_p;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    approx_mul_ha_row #(.N(N), .K(K)) u_row (
      .i_y      (r_y),
      .i_x0     (r_x[2*r]),
      .i_x1     (r_x[2*r+1]),
      .i_approx (r_ap),
      .o_row    (w_rows[r])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < ROWS; r++)
      w_sum = w_sum + (PW'(r_rows[r]) << (2 * r));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_ap       <= 1'b0;
      r_rows     <= '0;
      r_p        <= '0;
    end else begin
      if (w_ld1) r_vld_pipe[1] <= in_valid;
      if (w_ld1 & in_valid) begin
        r_x  <= in_x;
        r_y  <= in_y;
        r_ap <= in_approx;
      end
      if (w_ld2) r_vld_pipe[2] <= r_vld_pipe[1];
      if (w_ld2 & r_vld_pipe[1]) r_rows <= w_rows;
      if (w_ld3) r_vld_pipe[3] <= r_vld_pipe[2];
      if (w_ld3 & r_vld_pipe[2]) r_p <= w_sum;
    end
  end
endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Directed bench for approx_mul_ha_pipe: N=8/K=3 main instance plus N=4 and N=16 sweeps.

module tb_approx_mul_ha_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main N=8 K=3
  logic        in_valid, in_ready, in_approx, out_valid, out_ready;
  logic [7:0]  in_x, in_y;
  logic [15:0] out_p;
  // N=4 K=4 / K=0
  logic        v4, ap4, rdy4a, rdy4b, ov4a, ov4b;
  logic [3:0]  x4, y4;
  logic [7:0]  p4a, p4b;
  // N=16 K=0 / K=16
  logic        v16, ap16, rdy16a, rdy16b, ov16a, ov16b;
  logic [15:0] x16, y16;
  logic [31:0] p16a, p16b;
  logic        aux_ordy;

  approx_mul_ha_pipe #(.N(8), .K(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p));

  approx_mul_ha_pipe #(.N(4), .K(4)) d4a (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4a),
    .in_x(x4), .in_y(y4), .in_approx(ap4),
    .out_valid(ov4a), .out_ready(aux_ordy), .out_p(p4a));

  approx_mul_ha_pipe #(.N(4), .K(0)) d4b (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4b),
    .in_x(x4), .in_y(y4), .in_approx(ap4),
    .out_valid(ov4b), .out_ready(aux_ordy), .out_p(p4b));

  approx_mul_ha_pipe #(.N(16), .K(0)) d16a (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16a),
    .in_x(x16), .in_y(y16), .in_approx(ap16),
    .out_valid(ov16a), .out_ready(aux_ordy), .out_p(p16a));

  approx_mul_ha_pipe #(.N(16), .K(16)) d16b (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16b),
    .in_x(x16), .in_y(y16), .in_approx(ap16),
    .out_valid(ov16b), .out_ready(aux_ordy), .out_p(p16b));

  // Exact product minus the per-column loss: every approximated column with
  // both partial bits set gives up 2^j * 4^r relative to the true sum.
  function automatic longint unsigned model(int n, int k, longint unsigned x,
                                            longint unsigned y, bit ap);
    longint unsigned p;
    p = x * y;
    if (ap)
      for (int r = 0; r < n / 2; r++)
        for (int j = 1; j < n; j++)
          if (j < k && x[2*r] && x[2*r+1] && y[j] && y[j-1])
            p = p - (longint'(1) << (j + 2 * r));
    return p;
  endfunction

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic ap, input longint unsigned exp);
    @(negedge clk);
    in_valid = 1'b1; in_x = x; in_y = y; in_approx = ap;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_p, exp);
  endtask

  longint unsigned q8[$], q4a[$], q4b[$], q16a[$], q16b[$];
  int got, extra, last_i, acc;
  logic [7:0] bx, by;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_approx = 1'b0; out_ready = 1'b1;
    v4 = 1'b0; x4 = '0; y4 = '0; ap4 = 1'b0;
    v16 = 1'b0; x16 = '0; y16 = '0; ap16 = 1'b0; aux_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_p", out_p, 0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);

    // directed vectors, hand-computed
    beat8("ex_255x255", 8'd255, 8'd255, 1'b0, 65025);
    beat8("ex_3x3",     8'd3,   8'd3,   1'b0, 9);
    beat8("ap_3x3",     8'd3,   8'd3,   1'b1, 7);
    beat8("ap_255x255", 8'd255, 8'd255, 1'b1, 64515);
    beat8("ap_0x200",   8'd0,   8'd200, 1'b1, 0);
    beat8("ap_1x255",   8'd1,   8'd255, 1'b1, 255);

    // back-to-back stream, alternating mode
    got = 0; extra = 0; last_i = -1;
    for (int i = 0; i < 1008; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (q8.size() > 0) begin
          chk("stream", out_p, q8.pop_front());
          got++; last_i = i;
        end else extra++;
      end
      if (i < 1000) begin
        in_valid = 1'b1; in_x = 8'($urandom); in_y = 8'($urandom); in_approx = i[0];
        q8.push_back(model(8, 3, in_x, in_y, in_approx));
      end else in_valid = 1'b0;
    end
    chk("stream_count", got, 1000);
    chk("stream_extra", extra, 0);
    chk("stream_last_cycle", last_i, 1002);

    // backpressure: capacity 3, output held stable
    @(negedge clk);
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) chk("bp_hold", out_p, q8[0]);
      in_valid = 1'b1; in_x = 8'($urandom); in_y = 8'($urandom); in_approx = c[0];
      #1;
      if (in_ready) begin
        q8.push_back(model(8, 3, in_x, in_y, in_approx));
        acc++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepts", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    got = 0;
    for (int d = 0; d < 8; d++) begin
      if (out_valid) begin
        if (q8.size() > 0) begin chk("bp_drain", out_p, q8.pop_front()); got++; end
        else extra++;
      end
      @(negedge clk);
    end
    chk("bp_drain_count", got, 3);
    chk("bp_extra", extra, 0);

    // reset with three beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bx = 8'(c + 100); by = 8'(c + 7);
      in_valid = 1'b1; in_x = bx; in_y = by; in_approx = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("rf_full", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rf_valid", out_valid, 0);
    chk("rf_p", out_p, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("rf_in_ready", in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rf_no_stale", out_valid, 0);
    end

    // N=4 exhaustive, both modes, K=4 and K=0
    got = 0;
    for (int i = 0; i < 516; i++) begin
      @(negedge clk);
      if (ov4a && q4a.size() > 0) begin chk("n4k4", p4a, q4a.pop_front()); got++; end
      if (ov4b && q4b.size() > 0) begin chk("n4k0", p4b, q4b.pop_front()); got++; end
      if (i < 512) begin
        v4 = 1'b1; x4 = i[3:0]; y4 = i[7:4]; ap4 = i[8];
        q4a.push_back((x4 == 4'd15 && y4 == 4'd15 && ap4) ? 155 : model(4, 4, x4, y4, ap4));
        q4b.push_back(longint'(x4) * longint'(y4));
      end else v4 = 1'b0;
    end
    chk("n4_count", got, 1024);

    // N=16, K=0 exact regardless of mode; K=16 fully approximated
    got = 0;
    for (int i = 0; i < 204; i++) begin
      @(negedge clk);
      if (ov16a && q16a.size() > 0) begin chk("n16k0", p16a, q16a.pop_front()); got++; end
      if (ov16b && q16b.size() > 0) begin chk("n16k16", p16b, q16b.pop_front()); got++; end
      if (i == 0) begin
        v16 = 1'b1; x16 = 16'hFFFF; y16 = 16'hFFFF; ap16 = 1'b1;
        q16a.push_back(64'd4294836225);
        q16b.push_back(64'd2863245995);
      end else if (i < 200) begin
        v16 = 1'b1; x16 = 16'($urandom); y16 = 16'($urandom); ap16 = i[0];
        q16a.push_back(longint'(x16) * longint'(y16));
        q16b.push_back(model(16, 16, x16, y16, ap16));
      end else v16 = 1'b0;
    end
    chk("n16_count", got, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
